// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and leading-zero blanking helper for the
// sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int          DIGITS       = 8;
    localparam logic [31:0] BCD_MAX      = 32'd99_999_999;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Replace leading zero digits with BLANK_NIBBLE; digit 0 always stays lit.
    function automatic logic [31:0] blank_leading(input logic [31:0] bcd);
        logic [31:0] res;
        logic        lead;
        res  = bcd;
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && (bcd[d*4 +: 4] == 4'd0)) begin
                res[d*4 +: 4] = BLANK_NIBBLE;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_cell (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (one bit per clock) feeding the 8-digit
// scanner. Define BIN2BCD_BLANK_EN to blank leading zero digits with 4'hF.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] bin_in,
    output logic             in_ready,
    output logic [31:0]      bcd_out,
    output logic             out_valid,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);

`ifdef BIN2BCD_BLANK_EN
    localparam logic [31:0] RST_BCD = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] RST_BCD = 32'h0000_0000;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_bin;
    logic [31:0]      r_acc;
    logic             r_ovf_cand;
    logic             r_in_ready;
    logic [31:0]      r_bcd;
    logic             r_out_valid;
    logic             r_ovf;

    logic [31:0]      w_bin_ext;
    logic             w_ovf;
    logic [BIN_W-1:0] w_clamped;
    logic [31:0]      w_adj;
    logic [31:0]      w_next_acc;
    logic [31:0]      w_final;

    // Saturation can only trigger when BIN_W is wide enough to exceed BCD_MAX.
    assign w_bin_ext = 32'(bin_in);
    assign w_ovf     = (w_bin_ext > BCD_MAX);
    assign w_clamped = w_ovf ? BIN_W'(BCD_MAX) : bin_in;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3_cell u_cell (
            .i_digit (r_acc[d*4 +: 4]),
            .o_digit (w_adj[d*4 +: 4])
        );
    end

    assign w_next_acc = (w_adj << 1) | 32'(r_bin[BIN_W-1]);

`ifdef BIN2BCD_BLANK_EN
    assign w_final = blank_leading(w_next_acc);
`else
    assign w_final = w_next_acc;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bin       <= '0;
            r_acc       <= '0;
            r_ovf_cand  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_bcd       <= RST_BCD;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin      <= w_clamped;
                        r_ovf_cand <= w_ovf;
                        r_acc      <= '0;
                        r_cnt      <= CNT_W'(BIN_W);
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_next_acc;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Outputs move only here, so the scanner never sees partial results.
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd       <= w_final;
                        r_ovf       <= r_ovf_cand;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign bcd_out   = r_bcd;
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed and random values are converted by
// a decimal-arithmetic reference model; a monitor checks every out_valid pulse.
module tb_bin2bcd_seq;

    localparam int BIN_W = 27;

`ifdef BIN2BCD_BLANK_EN
    localparam logic [31:0] RST_BCD = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] RST_BCD = 32'h0000_0000;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             in_valid = 1'b0;
    logic [BIN_W-1:0] bin_in   = '0;
    logic             in_ready;
    logic [31:0]      bcd_out;
    logic             out_valid;
    logic             ovf;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bin_in    (bin_in),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          acc_edge;
        longint      val;
    } exp_t;

    exp_t   exp_q[$];
    int     pulse_cyc_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
    endtask

    // Decimal digits by repeated division; digit d is blank when value < 10^d.
    function automatic logic [31:0] ref_bcd(input longint v, output logic o);
        longint      c;
        longint      p;
        logic [31:0] r;
        o = (v > 64'd99_999_999);
        c = o ? 64'd99_999_999 : v;
        r = '0;
        p = c;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(p % 10);
            p = p / 10;
        end
`ifdef BIN2BCD_BLANK_EN
        p = 10;
        for (int d = 1; d < 8; d++) begin
            if (c < p) r[d*4 +: 4] = 4'hF;
            p = p * 10;
        end
`endif
        return r;
    endfunction

    // Caller is positioned at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input longint v);
        int   guard;
        exp_t e;
        logic o;
        in_valid = 1'b1;
        bin_in   = BIN_W'(v);
        guard    = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            fail_now("accept");
            in_valid = 1'b0;
            return;
        end
        e.bcd      = ref_bcd(v, o);
        e.ovf      = o;
        e.acc_edge = cyc + 1;
        e.val      = v;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || !in_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || !in_ready) begin
            fail_now("drain");
            exp_q.delete();
        end
    endtask

    logic [31:0] prev_bcd;
    logic        prev_rst = 1'b0;
    logic        prev_ov  = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (out_valid) begin
                n_pulses++;
                pulse_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out_valid: got bcd_out %h, expected no pulse", bcd_out);
                end else begin
                    e = exp_q.pop_front();
                    check("bcd_out", bcd_out, e.bcd);
                    check("ovf", 32'(ovf), 32'(e.ovf));
                    check("latency", 32'(cyc - e.acc_edge), 32'(BIN_W));
                end
            end else if (prev_rst) begin
                check("bcd_stable", bcd_out, prev_bcd);
            end
            if (prev_ov) begin
                check("out_valid_one_cycle", 32'(out_valid), 32'd0);
                check("in_ready_after_done", 32'(in_ready), 32'd1);
            end
        end
        prev_ov  = rst && out_valid;
        prev_rst = rst;
        prev_bcd = bcd_out;
    end

    initial begin : watchdog
        #300_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  p0;
        int  g;
        int  sel;
        longint v;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_bcd_out", bcd_out, RST_BCD);
        #2 rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        send(12_345_678);
        wait_drain();

        send(0);
        send(99_999_999);
        wait_drain();

        send(134_217_727);
        send(42);
        wait_drain();

        // Busy-period requests must be dropped.
        p0 = n_pulses;
        send(500);
        g = 0;
        while (!in_ready && g < 200) begin
            in_valid = 1'b1;
            bin_in   = BIN_W'(777);
            @(negedge clk);
            g++;
        end
        in_valid = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        check("ignored_requests_pulses", 32'(n_pulses - p0), 32'd1);
        check("ignored_requests_bcd", bcd_out, ref_bcd(500, sel[0]));

        // Reset in the middle of a conversion.
        p0 = n_pulses;
        send(8_888_888);
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("abort_bcd_out", bcd_out, RST_BCD);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("post_abort_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        check("post_abort_no_pulse", 32'(n_pulses - p0), 32'd0);
        check("post_abort_bcd_out", bcd_out, RST_BCD);
        send(31);
        wait_drain();

        // Back-to-back with in_valid held.
        send(100);
        send(5);
        wait_drain();
        check("b2b_gap", 32'(pulse_cyc_q[pulse_cyc_q.size()-1] - pulse_cyc_q[pulse_cyc_q.size()-2]),
              32'(BIN_W + 2));

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: v = longint'($urandom_range(0, (1 << BIN_W) - 1));
                1: v = longint'($urandom_range(0, 999));
                2: v = longint'($urandom_range(99_999_990, 100_000_010));
                default: begin
                    v = longint'($urandom_range(0, 99_999));
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                end
            endcase
            send(v);
        end
        wait_drain();
        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
